// File: rtl/cordic_atan_rom_if.sv
// rtl/cordic_atan_rom_if.sv - address/data bundle between the CORDIC datapath and the angle ROM
interface cordic_atan_rom_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    // The datapath drives the iteration index and consumes the angle.
    modport master (
        output addr,
        input  data
    );

    // The ROM consumes the index and returns the registered angle.
    modport slave (
        input  addr,
        output data
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - registered ROM of CORDIC micro-rotation angles atan(2^-i) in Q2.30
module cordic_atan_rom #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    cordic_atan_rom_if.slave    rom
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // Angle lookup: round(atan(2^-i) * 2^30); the default only catches X/Z addresses in simulation.
    always_comb begin
        data_d = '0;
        case (rom.addr)
            4'h0:    data_d = 32'h3243F6A9;
            4'h1:    data_d = 32'h1DAC6705;
            4'h2:    data_d = 32'h0FADBAFD;
            4'h3:    data_d = 32'h07F56EA7;
            4'h4:    data_d = 32'h03FEAB77;
            4'h5:    data_d = 32'h01FFD55C;
            4'h6:    data_d = 32'h00FFFAAB;
            4'h7:    data_d = 32'h007FFF55;
            4'h8:    data_d = 32'h003FFFEB;
            4'h9:    data_d = 32'h001FFFFD;
            4'hA:    data_d = 32'h00100000;
            4'hB:    data_d = 32'h00080000;
            4'hC:    data_d = 32'h00040000;
            4'hD:    data_d = 32'h00020000;
            4'hE:    data_d = 32'h00010000;
            4'hF:    data_d = 32'h00008000;
            default: data_d = 'x;
        endcase
    end

    // Output register: no enable, so a stable address keeps the angle stable; reset clears it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rom.data = data_q;

endmodule

// File: tb/tb_cordic_atan_rom.sv
// tb/tb_cordic_atan_rom.sv - self-checking bench for the CORDIC angle ROM
module tb_cordic_atan_rom;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cordic_atan_rom_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    cordic_atan_rom #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rom (bus.slave)
    );

    logic [31:0] spec_tbl [16];
    logic [31:0] model_tbl [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference angle computed directly from atan(2^-i) * 2^30, rounded to nearest.
    function automatic logic [31:0] model_angle(input int i);
        real a;
        a = $atan(1.0 / (2.0 ** i)) * 1073741824.0;
        return 32'($rtoi(a + 0.5));
    endfunction

    task automatic test_reset();
        @(negedge clk);
        bus.addr = 4'h3;
        @(posedge clk);
        #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.data !== 32'h0) begin
            failures++;
            $display("FAIL reset_async actual=%08h expected=%08h", bus.data, 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.data !== 32'h0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d actual=%08h expected=%08h", k, bus.data, 32'h0);
            end
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        bus.addr = 4'h0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.data !== 32'h0) begin
            failures++;
            $display("FAIL release_before_edge actual=%08h expected=%08h", bus.data, 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            bus.addr = 4'(i);
            @(posedge clk);
            #1;
            checks++;
            if (bus.data !== spec_tbl[i]) begin
                failures++;
                $display("FAIL sweep addr=%0h actual=%08h expected=%08h", i, bus.data, spec_tbl[i]);
            end
        end
    endtask

    task automatic test_latency();
        bus.addr = 4'h2;
        @(posedge clk);
        #1;
        bus.addr = 4'h9;
        #2;
        checks++;
        if (bus.data !== 32'h0FADBAFD) begin
            failures++;
            $display("FAIL latency_hold actual=%08h expected=%08h", bus.data, 32'h0FADBAFD);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.data !== 32'h001FFFFD) begin
            failures++;
            $display("FAIL latency_update actual=%08h expected=%08h", bus.data, 32'h001FFFFD);
        end
    endtask

    task automatic test_hold();
        bus.addr = 4'hA;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.data !== 32'h00100000) begin
                failures++;
                $display("FAIL hold cycle=%0d actual=%08h expected=%08h", k, bus.data, 32'h00100000);
            end
            #3;
            checks++;
            if (bus.data !== 32'h00100000) begin
                failures++;
                $display("FAIL hold_mid cycle=%0d actual=%08h expected=%08h", k, bus.data, 32'h00100000);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.addr = 4'h3;
        @(posedge clk);
        #1;
        checks++;
        if (bus.data !== 32'h07F56EA7) begin
            failures++;
            $display("FAIL mid_pre actual=%08h expected=%08h", bus.data, 32'h07F56EA7);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.data !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset actual=%08h expected=%08h", bus.data, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.addr = 4'h4;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.data !== 32'h03FEAB77) begin
            failures++;
            $display("FAIL mid_release actual=%08h expected=%08h", bus.data, 32'h03FEAB77);
        end
    endtask

    task automatic test_random();
        int a;
        for (int n = 0; n < 200; n++) begin
            a = $urandom_range(0, 15);
            bus.addr = 4'(a);
            @(posedge clk);
            #1;
            checks++;
            if (bus.data !== model_tbl[a]) begin
                failures++;
                $display("FAIL random n=%0d addr=%0h actual=%08h expected=%08h", n, a, bus.data, model_tbl[a]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        spec_tbl = '{32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
                     32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
                     32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
                     32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000};
        for (int i = 0; i < 16; i++) model_tbl[i] = model_angle(i);
        rst      = 1'b0;
        bus.addr = 4'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_sweep();
        test_latency();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_atan_rom.md
Name: cordic_atan_rom

Overview:
Synchronous read-only lookup table holding the 16 CORDIC micro-rotation angles atan(2^-i), i = 0..15. Each value is a 32-bit signed fixed-point angle in radians. The CORDIC iteration datapath indexes the table by iteration number and receives the angle one clock later. The block has no write path; contents are fixed at elaboration.

Parameters:
DATA_W, 32, output word width. Fixed; contents are defined only for 32.
ADDR_W, 4, address width. Depth is 2^ADDR_W = 16 entries.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
addr  input  4  table index = CORDIC iteration number i
data  output  32  registered table word, atan(2^-i) in Q2.30 radians

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Number format: Q2.30 two's complement, value = round(atan(2^-i) * 2^30). All entries are positive.
- Table contents (addr -> data):
  - 0 -> 3243F6A9
  - 1 -> 1DAC6705
  - 2 -> 0FADBAFD
  - 3 -> 07F56EA7
  - 4 -> 03FEAB77
  - 5 -> 01FFD55C
  - 6 -> 00FFFAAB
  - 7 -> 007FFF55
  - 8 -> 003FFFEB
  - 9 -> 001FFFFD
  - A -> 00100000
  - B -> 00080000
  - C -> 00040000
  - D -> 00020000
  - E -> 00010000
  - F -> 00008000
- Read timing: data is a register. On each rising clk edge with rst low, data <= table[addr].
- Latency is exactly 1 cycle. An addr value presented before edge N appears on data after edge N. It holds until the next edge.
- No enable: the register updates on every edge, so a stable addr keeps data stable.
- Reset: rst high forces data to 00000000 immediately, without waiting for a clock edge. data stays 0 while rst is high.
- Reset release: the first rising edge with rst low loads table[addr]. Deasserting rst mid-cycle does not change data until that edge.
- addr covers the full 16-entry depth. There is no out-of-range case and no wrap logic.
- addr containing X/Z bits during simulation: data becomes X. Synthesis must still produce a pure mux/ROM.
- No combinational path from addr to data.
- Implementation: case statement or initialised constant array. Must be inferable as a LUT-ROM.

Test Plan:
- Reset: assert rst asynchronously between clock edges with addr=3 -> data = 00000000 immediately, and stays 0 across edges while rst=1.
- Sequential sweep: release rst, drive addr 0..F, one per cycle -> after each edge data equals the table entry for the address sampled at that edge. For example, addr 0 -> 3243F6A9, addr 1 -> 1DAC6705, addr F -> 00008000.
- Latency: change addr from 2 to 9 just after an edge -> data keeps 0FADBAFD until the next edge, then shows 001FFFFD.
- Hold: keep addr=A for 5 cycles -> data = 00100000 on every cycle, with no glitching.
- Reset mid-sweep: assert rst while data = 07F56EA7 (addr 3) -> data = 0 at once. Release with addr=4 -> the first edge gives 03FEAB77.
- Random addresses: 200 random addr values -> every registered output matches a reference model computed as round(atan(2^-i)*2^30).
